// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32I core: steps the shared ALU and memory port
// through fetch, decode, execute, memory and writeback for each instruction class.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] code,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       ir_load,
  output logic       pc_load,
  output logic [1:0] pc_src,
  output logic       alu_sel_a,
  output logic       alu_sel_b,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       instr_done,
  output logic       halted,
  output logic [1:0] trap_cause
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam int unsigned C_J     = 0;
  localparam int unsigned C_JALR  = 1;
  localparam int unsigned C_LUI   = 2;
  localparam int unsigned C_AUIPC = 3;
  localparam int unsigned C_B     = 4;
  localparam int unsigned C_R     = 5;
  localparam int unsigned C_S     = 6;
  localparam int unsigned C_IALU  = 7;
  localparam int unsigned C_LOAD  = 8;
  localparam int unsigned C_CSR   = 9;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_CSR     = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_TRAP
  } state_e;

  state_e           state_q, state_d;
  logic [9:0]       code_q, code_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             timeout_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      code_q  <= '0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  assign trap_cause = cause_q;

  // A request gives up only if the last allowed cycle also sees no mem_ready.
  assign timeout_c = (cnt_q == CNT_LAST) && !mem_ready;

  // Outputs are forced low while reset is asserted so an aborted access cannot leak.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    taken_d      = taken_q;
    cnt_d        = '0;
    cause_d      = cause_q;
    ir_load      = 1'b0;
    pc_load      = 1'b0;
    pc_src       = 2'b00;
    alu_sel_a    = 1'b0;
    alu_sel_b    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'b00;
    instr_done   = 1'b0;
    halted       = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load = 1'b1;
            state_d = S_DECODE;
          end else if (timeout_c) begin
            cause_d = CAUSE_TIMEOUT;
            state_d = S_TRAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DECODE: begin
          code_d = code;
          if (!$onehot(code)) begin
            cause_d = CAUSE_ILLEGAL;
            state_d = S_TRAP;
          end else if (code[C_CSR]) begin
            cause_d = CAUSE_CSR;
            state_d = S_TRAP;
          end else begin
            state_d = S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          alu_sel_a = code_q[C_J] | code_q[C_AUIPC];
          alu_sel_b = ~(code_q[C_B] | code_q[C_R]);
          taken_d   = branch_taken;
          state_d   = (code_q[C_S] | code_q[C_LOAD]) ? S_MEMORY : S_WRITEBACK;
        end
        S_MEMORY: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = code_q[C_S];
          if (mem_ready) begin
            if (code_q[C_S]) begin
              pc_load    = 1'b1;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end else begin
              state_d = S_WRITEBACK;
            end
          end else if (timeout_c) begin
            cause_d = CAUSE_TIMEOUT;
            state_d = S_TRAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WRITEBACK: begin
          pc_load    = 1'b1;
          instr_done = 1'b1;
          reg_write  = code_q[C_J] | code_q[C_JALR] | code_q[C_LUI] | code_q[C_AUIPC] |
                       code_q[C_R] | code_q[C_IALU] | code_q[C_LOAD];
          if (code_q[C_J] | code_q[C_JALR]) begin
            wb_sel = 2'b10;
          end else if (code_q[C_LUI]) begin
            wb_sel = 2'b11;
          end else if (code_q[C_LOAD]) begin
            wb_sel = 2'b01;
          end
          if (code_q[C_JALR]) begin
            pc_src = 2'b01;
          end else if (code_q[C_J] | (code_q[C_B] & taken_q)) begin
            pc_src = 2'b10;
          end
          state_d = S_FETCH;
        end
        S_TRAP: begin
          halted = 1'b1;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a driver issues instructions and pushes
// expected retirement/trap records; a monitor pops and compares on instr_done/halted.
module tb_multicycle_control;

  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int C_J = 0, C_JALR = 1, C_LUI = 2, C_AUIPC = 3, C_B = 4;
  localparam int C_R = 5, C_S = 6, C_IALU = 7, C_LOAD = 8;
  localparam int NEVER = 1000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] code = '0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ir_load, pc_load, alu_sel_a, alu_sel_b, mem_req, mem_we, mem_addr_sel;
  logic       reg_write, instr_done, halted;
  logic [1:0] pc_src, wb_sel, trap_cause;
  logic [16:0] all_out;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .code(code), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .ir_load(ir_load), .pc_load(pc_load), .pc_src(pc_src),
    .alu_sel_a(alu_sel_a), .alu_sel_b(alu_sel_b), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .reg_write(reg_write), .wb_sel(wb_sel),
    .instr_done(instr_done), .halted(halted), .trap_cause(trap_cause)
  );

  assign all_out = {ir_load, pc_load, pc_src, alu_sel_a, alu_sel_b, mem_req, mem_we,
                    mem_addr_sel, reg_write, wb_sel, instr_done, halted, trap_cause};

  typedef struct {
    int cycles;
    bit sel_a;
    bit sel_b;
    bit rw;
    int wb;
    int pcs;
    bit we;
  } exp_t;

  typedef struct {
    int cycles;
    int cause;
  } texp_t;

  exp_t  retire_q[$];
  texp_t trap_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cur_fw = 0;
  int    cur_mw = 0;
  int    wcnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of one retired instruction, straight from the class tables.
  function automatic exp_t model(input int cls, input bit taken, input int fw, input int mw);
    exp_t e;
    bit   is_mem;
    is_mem  = (cls == C_S) || (cls == C_LOAD);
    e.sel_a = (cls == C_J) || (cls == C_AUIPC);
    e.sel_b = !((cls == C_B) || (cls == C_R));
    e.rw    = !((cls == C_B) || (cls == C_S));
    e.we    = (cls == C_S);
    case (cls)
      C_J, C_JALR: e.wb = 2;
      C_LUI:       e.wb = 3;
      C_LOAD:      e.wb = 1;
      default:     e.wb = 0;
    endcase
    case (cls)
      C_JALR:  e.pcs = 1;
      C_J:     e.pcs = 2;
      C_B:     e.pcs = taken ? 2 : 0;
      default: e.pcs = 0;
    endcase
    e.cycles = (fw + 1) + 1 + 1 + (is_mem ? mw + 1 : 0) + ((cls == C_S) ? 0 : 1);
    return e;
  endfunction

  // One clock: answer the memory after the planned number of wait cycles.
  task automatic step(output bit done);
    int target;
    @(negedge clk);
    if (mem_req) begin
      target = mem_addr_sel ? cur_mw : cur_fw;
      if (wcnt >= target) begin
        mem_ready = 1'b1;
        wcnt = 0;
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ready = 1'($urandom);
    end
    #1 done = instr_done;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wcnt = 0;
    mem_ready = 1'b0;
    retire_q.delete();
    trap_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic run_instr(input int cls, input bit taken, input int fw, input int mw);
    bit done;
    int n;
    code = 10'(32'd1 << cls);
    branch_taken = taken;
    cur_fw = fw;
    cur_mw = mw;
    retire_q.push_back(model(cls, taken, fw, mw));
    done = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      step(done);
      n++;
    end
    chk("retire_wait", int'(done), 1);
  endtask

  task automatic run_trap(input logic [9:0] c, input int fw, input int mw,
                          input int cause, input int cyc);
    texp_t t;
    bit    done;
    int    n;
    code = c;
    branch_taken = 1'($urandom);
    cur_fw = fw;
    cur_mw = mw;
    t.cycles = cyc;
    t.cause = cause;
    trap_q.push_back(t);
    n = 0;
    while (!halted && n < 200) begin
      step(done);
      n++;
    end
    chk("trap_wait", int'(halted), 1);
    repeat (3) step(done);
    chk("trap_held_halted", int'(halted), 1);
    chk("trap_held_cause", int'(trap_cause), cause);
    chk("trap_no_mem_req", int'(mem_req), 0);
    chk("trap_no_pc_load", int'(pc_load), 0);
    do_reset();
  endtask

  // Monitor: per-instruction bookkeeping, compared when the DUT retires or traps.
  int    m_cyc = 0, m_ir = 0, m_rw = 0, m_pl = 0;
  bit    m_sa = 0, m_sb = 0, m_we = 0, m_trap = 0;
  exp_t  m_e;
  texp_t m_t;

  always @(negedge clk) begin
    #2;
    if (!reset_n) begin
      m_cyc = 0; m_ir = 0; m_rw = 0; m_pl = 0;
      m_sa = 0; m_sb = 0; m_we = 0; m_trap = 0;
    end else if (!m_trap) begin
      m_cyc++;
      if (ir_load) m_ir = m_cyc;
      if (m_ir != 0 && m_cyc == m_ir + 2) begin
        m_sa = alu_sel_a;
        m_sb = alu_sel_b;
      end
      m_we = m_we | mem_we;
      m_rw += int'(reg_write);
      m_pl += int'(pc_load);
      if (halted) begin
        m_trap = 1;
        if (trap_q.size() == 0) begin
          chk("unexpected_trap", 1, 0);
        end else begin
          m_t = trap_q.pop_front();
          chk("trap_cause", int'(trap_cause), m_t.cause);
          chk("trap_cycles", m_cyc, m_t.cycles);
          chk("trap_pc_loads", m_pl, 0);
          chk("trap_reg_writes", m_rw, 0);
        end
      end else if (instr_done) begin
        if (retire_q.size() == 0) begin
          chk("unexpected_retire", 1, 0);
        end else begin
          m_e = retire_q.pop_front();
          chk("cycles", m_cyc, m_e.cycles);
          chk("alu_sel_a", int'(m_sa), int'(m_e.sel_a));
          chk("alu_sel_b", int'(m_sb), int'(m_e.sel_b));
          chk("reg_write", int'(reg_write), int'(m_e.rw));
          chk("reg_write_count", m_rw, int'(m_e.rw));
          chk("wb_sel", int'(wb_sel), m_e.wb);
          chk("pc_src", int'(pc_src), m_e.pcs);
          chk("mem_we_seen", int'(m_we), int'(m_e.we));
          chk("pc_load", int'(pc_load), 1);
        end
        m_cyc = 0; m_ir = 0; m_rw = 0; m_pl = 0;
        m_sa = 0; m_sb = 0; m_we = 0;
      end
    end
  end

  initial begin
    bit done;
    int cls, fw, mw, seen;

    #1 chk("reset_outputs", int'(all_out), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    repeat (3) run_instr(C_R, 1'b0, 0, 0);
    run_instr(C_B, 1'b1, 0, 0);
    run_instr(C_B, 1'b0, 0, 0);
    run_instr(C_LOAD, 1'b0, 0, 3);
    run_instr(C_S, 1'b0, 0, 0);
    run_instr(C_R, 1'b0, 15, 0);
    run_instr(C_S, 1'b0, 2, 15);

    for (int i = 0; i < 80; i++) begin
      cls = int'($urandom_range(0, 8));
      fw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      mw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      run_instr(cls, 1'($urandom), fw, mw);
    end

    // Abort a store stalled in its memory phase.
    code = 10'(32'd1 << C_S);
    cur_fw = 0;
    cur_mw = NEVER;
    seen = 0;
    for (int n = 0; n < 40 && seen < 3; n++) begin
      step(done);
      if (mem_req && mem_addr_sel) seen++;
    end
    chk("store_we_before_reset", int'(mem_we), 1);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_outputs", int'(all_out), 0);
    wcnt = 0;
    mem_ready = 1'b0;
    retire_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    run_instr(C_R, 1'b0, 0, 0);
    run_instr(C_J, 1'b0, 1, 0);

    run_trap(10'b0000000011, 0, 0, 1, 3);
    run_trap(10'b1000000000, 1, 0, 2, 4);
    run_trap(10'b0000000000, 0, 0, 1, 3);
    run_trap(10'(32'd1 << C_R), NEVER, 0, 3, MEM_TIMEOUT + 1);
    run_trap(10'(32'd1 << C_LOAD), 0, NEVER, 3, 3 + MEM_TIMEOUT + 1);
    run_trap(10'(32'd1 << C_S), 2, NEVER, 3, 5 + MEM_TIMEOUT + 1);

    run_instr(C_AUIPC, 1'b0, 0, 0);
    run_instr(C_JALR, 1'b0, 0, 0);
    @(negedge clk);
    #3 chk("retire_queue_drained", retire_q.size(), 0);
    chk("trap_queue_drained", trap_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencer for the RV32I core. Takes the one-hot 10-bit instruction-class code from the decoder and steps the shared datapath through fetch, decode, execute, memory and writeback. It drives the ALU operand selects, PC/IR load strobes, memory request/handshake and register write-back. It sits in the control unit and replaces per-class combinational selects with a state machine that owns the single ALU and single memory port.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request waits for mem_ready before trapping (counter width = clog2(MEM_TIMEOUT+1))

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
code  in  10  one-hot class: [0]J [1]JALR [2]LUI [3]AUIPC [4]B [5]R [6]S [7]I-ALU [8]LOAD [9]CSR
branch_taken  in  1  datapath compare result, valid in EXECUTE
mem_ready  in  1  memory completes current request this cycle
ir_load  out  1  latch instruction register
pc_load  out  1  update PC
pc_src  out  2  00 pc+4, 01 alu_out (JALR), 10 pc+imm
alu_sel_a  out  1  1=PC, 0=rs1
alu_sel_b  out  1  1=imm, 0=rs2
mem_req  out  1  memory request
mem_we  out  1  write (valid with mem_req)
mem_addr_sel  out  1  0=PC, 1=alu_out
reg_write  out  1  register file write enable
wb_sel  out  2  00 alu_out, 01 mem data, 10 pc+4, 11 imm
instr_done  out  1  one-cycle pulse on retirement
halted  out  1  high in TRAP
trap_cause  out  2  00 none, 01 illegal code, 10 CSR, 11 mem timeout

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. reset_n low -> state FETCH, code_q=0, taken_q=0, timeout counter=0, trap_cause=00; all outputs 0. Reset mid-instruction aborts it; no partial writes after release.
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP. Outputs are Moore from state/code_q/taken_q, plus mem_ready gating. Unlisted outputs are 0.
- FETCH: mem_req=1, mem_addr_sel=0. On mem_ready, ir_load=1 the same cycle -> DECODE.
- DECODE: code_q<=code. Not exactly one bit set -> TRAP, cause 01. code[9] -> TRAP, cause 10. Otherwise -> EXECUTE.
- EXECUTE: alu_sel_a=1 for J, AUIPC; 0 for JALR, B, R, S, I-ALU, LOAD, LUI. alu_sel_b=1 for J, JALR, AUIPC, S, I-ALU, LOAD, LUI; 0 for B, R. taken_q<=branch_taken. S/LOAD -> MEMORY; else -> WRITEBACK.
- MEMORY: mem_req=1, mem_addr_sel=1, mem_we=1 for S. On mem_ready: LOAD -> WRITEBACK; S asserts pc_load=1 (pc_src 00) and instr_done=1 the same cycle -> FETCH.
- WRITEBACK (one cycle): pc_load=1, instr_done=1, -> FETCH.
  - reg_write=1 for J, JALR, LUI, AUIPC, R, I-ALU, LOAD; 0 for B.
  - wb_sel: J/JALR 10, LUI 11, LOAD 01, others 00.
  - pc_src: JALR 01; J 10; B 10 if taken_q else 00; others 00.
- Memory timeout: the counter clears on entry to FETCH/MEMORY and increments each cycle mem_req=1 and mem_ready=0. When it reaches MEM_TIMEOUT with mem_ready still 0 -> TRAP, cause 11. mem_ready in that same cycle wins (normal completion).
- TRAP: halted=1, trap_cause held, all strobes 0. Exit only via reset.
- Cycle counts with zero-wait memory: R/I-ALU/J/JALR/LUI/AUIPC/B = 4 cycles; LOAD = 5; S = 4.

Test Plan:
- Reset asserted mid-MEMORY of a store, mem_ready=0 -> all outputs 0 immediately (async), mem_we never asserts after release, fetch restarts in FETCH.
- code=10'b0000100000 (R), mem_ready=1 always -> ir_load@cycle1; EXECUTE alu_sel_a=0, alu_sel_b=0; WRITEBACK reg_write=1, wb_sel=00, pc_src=00; instr_done every 4 cycles.
- code=10'b0000010000 (B), branch_taken=1 then 0 on the next instruction -> pc_src=10 then 00, reg_write=0 both times, alu_sel_b=0 in EXECUTE.
- code=10'b0100000000 (LOAD), mem_ready low 3 cycles in MEMORY -> mem_req/mem_addr_sel=1 held 4 cycles, then WRITEBACK with wb_sel=01, reg_write=1; instruction takes 8 cycles.
- code=10'b0000000011 and, after reset, code=10'b1000000000 -> TRAP with trap_cause 01 and 10 respectively, halted=1, no pc_load/reg_write.
- MEM_TIMEOUT=16, mem_ready held 0 in FETCH -> halted=1, trap_cause=11 after 16 cycles; repeat with mem_ready=1 on cycle 16 -> DECODE, no trap.
